// File: rtl/matmul_result_drain_if.sv
// Row-stream bus from the result drain toward writeback/memory.
// Valid/ready handshake carrying one requantized 8-lane row per beat.
`default_nettype none

interface matmul_result_drain_if #(
  parameter int OUT_WIDTH = 8
) ();
  logic                   m_valid;
  logic                   m_ready;
  logic [OUT_WIDTH*8-1:0] m_data;
  logic [2:0]             m_row;
  logic                   m_last;
  logic [7:0]             m_sat;

  modport master (output m_valid, m_data, m_row, m_last, m_sat, input m_ready);
  modport slave  (input m_valid, m_data, m_row, m_last, m_sat, output m_ready);
endinterface

`default_nettype wire

// File: rtl/matmul_result_drain.sv
// ---------------------------------------------------------------------------
// matmul_result_drain: captures the 8x8 accumulator matrix on done rising,
// requantizes (round/shift/saturate) and streams it one row per beat.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module matmul_result_drain #(
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT_W   = 4
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   done_in,
  input  wire logic [ACC_WIDTH*64-1:0] C_matrix,
  input  wire logic [SHIFT_W-1:0]     shift_amt,
  matmul_result_drain_if.master       m,
  output logic                        busy,
  output logic                        overrun
);

  localparam logic signed [ACC_WIDTH:0] c_ONE  = (ACC_WIDTH+1)'(1);
  localparam logic signed [ACC_WIDTH:0] c_OMAX = (ACC_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] c_OMIN = ~c_OMAX;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 done_prev_q;
  logic [2:0]           row_q, row_d;
  logic                 overrun_q, overrun_d;
  logic [OUT_WIDTH-1:0] buf_q [64];
  logic [63:0]          sat_q;

  logic [OUT_WIDTH-1:0] w_qout [64];
  logic [63:0]          w_qsat;
  logic                 w_trig;
  logic                 w_capture;

  // One requantizer per element; extra MSB keeps the rounding add from overflowing.
  generate
    for (genvar i = 0; i < 64; i++) begin : g_req
      logic signed [ACC_WIDTH:0] w_x, w_rnd, w_t, w_v;
      assign w_x   = {C_matrix[i*ACC_WIDTH + ACC_WIDTH - 1], C_matrix[i*ACC_WIDTH +: ACC_WIDTH]};
      assign w_rnd = (shift_amt == '0) ? '0 : (c_ONE << (shift_amt - SHIFT_W'(1)));
      assign w_t   = w_x + w_rnd;
      assign w_v   = w_t >>> shift_amt;
      assign w_qsat[i] = (w_v > c_OMAX) || (w_v < c_OMIN);
      assign w_qout[i] = (w_v > c_OMAX) ? c_OMAX[OUT_WIDTH-1:0] :
                         (w_v < c_OMIN) ? c_OMIN[OUT_WIDTH-1:0] : w_v[OUT_WIDTH-1:0];
    end
  endgenerate

  assign w_trig = done_in & ~done_prev_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    overrun_d = overrun_q;
    w_capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_trig) begin
          w_capture = 1'b1;
          state_d   = S_STREAM;
          row_d     = 3'd0;
        end
      end
      S_STREAM: begin
        if (w_trig) overrun_d = 1'b1;
        if (m.m_ready) begin
          if (row_q == 3'd7) begin
            state_d = S_IDLE;
            row_d   = 3'd0;
          end else begin
            row_d = row_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_q       <= 3'd0;
      overrun_q   <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      overrun_q   <= overrun_d;
      done_prev_q <= done_in;
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < 64; i++) buf_q[i] <= w_qout[i];
      sat_q <= w_qsat;
    end
  end

  assign m.m_valid = (state_q == S_STREAM);
  assign m.m_row   = row_q;
  assign m.m_last  = m.m_valid & (row_q == 3'd7);
  assign busy      = m.m_valid;
  assign overrun   = overrun_q;

  generate
    for (genvar c = 0; c < 8; c++) begin : g_lane
      assign m.m_data[c*OUT_WIDTH +: OUT_WIDTH] = m.m_valid ? buf_q[{row_q, 3'(c)}] : '0;
      assign m.m_sat[c] = m.m_valid & sat_q[{row_q, 3'(c)}];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_matmul_result_drain.sv
// Directed self-checking bench for matmul_result_drain.
`default_nettype none

module tb_matmul_result_drain;
  localparam int ACC_WIDTH = 16;
  localparam int OUT_WIDTH = 8;
  localparam int SHIFT_W   = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    done_in;
  logic [ACC_WIDTH*64-1:0] C_matrix;
  logic [SHIFT_W-1:0]      shift_amt;
  logic                    busy, overrun;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  matmul_result_drain_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

  matmul_result_drain #(
    .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .reset(reset), .done_in(done_in), .C_matrix(C_matrix),
    .shift_amt(shift_amt), .m(bus), .busy(busy), .overrun(overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_elem(input int r, input int c, input int v);
    C_matrix[(r*8+c)*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(v);
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) set_elem(r, c, v);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) set_elem(r, c, r*8 + c);
  endtask

  function automatic logic [OUT_WIDTH*8-1:0] ramp_row(input int r);
    logic [OUT_WIDTH*8-1:0] res;
    for (int c = 0; c < 8; c++) res[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(r*8 + c);
    return res;
  endfunction

  task automatic drain();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 20 && bus.m_valid; k++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; done_in = 1'b0; bus.m_ready = 1'b0; shift_amt = '0; C_matrix = '0;
    tick(); tick();
    checks++;
    if ({bus.m_valid, busy, overrun, bus.m_last} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {bus.m_valid, busy, overrun, bus.m_last});
    end
    checks++;
    if ({bus.m_row, bus.m_sat, bus.m_data} !== '0) begin
      failures++; $display("FAIL reset_row_data: row=%0d sat=%h data=%h expected all zero", bus.m_row, bus.m_sat, bus.m_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    fill_const(100); shift_amt = 4'd2; bus.m_ready = 1'b1; done_in = 1'b1;
    tick();
    for (int r = 0; r < 8; r++) begin
      checks++;
      if ({bus.m_valid, busy} !== 2'b11 || bus.m_row !== 3'(r)) begin
        failures++; $display("FAIL basic_row%0d_ctrl: valid=%b busy=%b row=%0d expected 1 1 %0d", r, bus.m_valid, busy, bus.m_row, r);
      end
      checks++;
      if (bus.m_data !== {8{8'd25}} || bus.m_sat !== 8'h00) begin
        failures++; $display("FAIL basic_row%0d_data: data=%h sat=%h expected %h 00", r, bus.m_data, bus.m_sat, {8{8'd25}});
      end
      checks++;
      if (bus.m_last !== (r == 7)) begin
        failures++; $display("FAIL basic_row%0d_last: got %b expected %b", r, bus.m_last, (r == 7));
      end
      tick();
    end
    checks++;
    if ({bus.m_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL basic_end: valid=%b busy=%b expected 0 0 (no retrigger on held done)", bus.m_valid, busy);
    end
    done_in = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    fill_const(0); set_elem(0, 0, 300); set_elem(0, 1, -300); set_elem(0, 2, 127);
    shift_amt = 4'd0; done_in = 1'b1;
    tick();
    checks++;
    if (bus.m_data !== {40'h0, 8'h7f, 8'h80, 8'h7f} || bus.m_sat !== 8'b0000_0011) begin
      failures++; $display("FAIL sat_row0: data=%h sat=%b expected %h 00000011", bus.m_data, bus.m_sat, {40'h0, 8'h7f, 8'h80, 8'h7f});
    end
    drain();
    checks++;
    if (bus.m_valid !== 1'b0) begin
      failures++; $display("FAIL sat_drain: valid=%b expected 0", bus.m_valid);
    end
    done_in = 1'b0;
    tick();
  endtask

  task automatic test_rounding();
    fill_const(0); set_elem(0, 0, 6); set_elem(0, 1, -6); set_elem(0, 2, -7); set_elem(0, 3, 7);
    shift_amt = 4'd2; done_in = 1'b1;
    tick();
    checks++;
    if (bus.m_data !== {32'h0, 8'h02, 8'hfe, 8'hff, 8'h02} || bus.m_sat !== 8'h00) begin
      failures++; $display("FAIL round_shift2: data=%h sat=%h expected %h 00", bus.m_data, bus.m_sat, {32'h0, 8'h02, 8'hfe, 8'hff, 8'h02});
    end
    drain();
    done_in = 1'b0;
    tick();
    fill_const(0); set_elem(0, 0, 5); set_elem(0, 1, -5);
    shift_amt = 4'd1; done_in = 1'b1;
    tick();
    checks++;
    if (bus.m_data !== {48'h0, 8'hfe, 8'h03} || bus.m_sat !== 8'h00) begin
      failures++; $display("FAIL round_shift1: data=%h sat=%h expected %h 00", bus.m_data, bus.m_sat, {48'h0, 8'hfe, 8'h03});
    end
    drain();
    done_in = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    int hs = 0;
    int exp_row = 0;
    fill_ramp(); shift_amt = 4'd0; done_in = 1'b1;
    tick();
    for (int k = 0; k < 60 && hs < 8; k++) begin
      bus.m_ready = pat[k % 6][0];
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_row !== 3'(exp_row) || bus.m_data !== ramp_row(exp_row)) begin
        failures++; $display("FAIL bp_cycle%0d: valid=%b row=%0d data=%h expected 1 %0d %h", k, bus.m_valid, bus.m_row, bus.m_data, exp_row, ramp_row(exp_row));
      end
      if (bus.m_valid && bus.m_ready) begin
        hs++;
        exp_row++;
      end
      tick();
    end
    checks++;
    if (hs != 8 || bus.m_valid !== 1'b0) begin
      failures++; $display("FAIL bp_handshakes: got %0d valid=%b expected 8 0", hs, bus.m_valid);
    end
    done_in = 1'b0;
    tick();
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_pre: got %b expected 0", overrun);
    end
    fill_ramp(); shift_amt = 4'd0; bus.m_ready = 1'b1; done_in = 1'b1;
    tick();
    for (int r = 0; r < 8; r++) begin
      if (r == 1) done_in = 1'b0;
      if (r == 3) done_in = 1'b1;
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_row !== 3'(r) || bus.m_data !== ramp_row(r)) begin
        failures++; $display("FAIL ovr_row%0d: valid=%b row=%0d data=%h expected 1 %0d %h", r, bus.m_valid, bus.m_row, bus.m_data, r, ramp_row(r));
      end
      checks++;
      if (overrun !== (r >= 4)) begin
        failures++; $display("FAIL ovr_flag_row%0d: got %b expected %b", r, overrun, (r >= 4));
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.m_valid !== 1'b0 || overrun !== 1'b1) begin
        failures++; $display("FAIL ovr_after%0d: valid=%b overrun=%b expected 0 1", k, bus.m_valid, overrun);
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    done_in = 1'b0;
    tick();
    done_in = 1'b1; bus.m_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (bus.m_row !== 3'd4 || bus.m_valid !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre: row=%0d valid=%b expected 4 1", bus.m_row, bus.m_valid);
    end
    reset = 1'b1; done_in = 1'b0;
    tick();
    checks++;
    if ({bus.m_valid, busy, overrun} !== 3'b000 || bus.m_row !== 3'd0) begin
      failures++; $display("FAIL rst_mid: valid=%b busy=%b overrun=%b row=%0d expected 0 0 0 0", bus.m_valid, busy, overrun, bus.m_row);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.m_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_quiet: valid=%b expected 0", bus.m_valid);
    end
    done_in = 1'b1;
    tick();
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_row !== 3'(r) || bus.m_data !== ramp_row(r)) begin
        failures++; $display("FAIL rst_restream_row%0d: valid=%b row=%0d data=%h expected 1 %0d %h", r, bus.m_valid, bus.m_row, bus.m_data, r, ramp_row(r));
      end
      tick();
    end
    checks++;
    if ({bus.m_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL rst_restream_end: valid=%b busy=%b expected 0 0", bus.m_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_overrun();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/matmul_result_drain.md
Name: matmul_result_drain

Overview:
- Downstream consumer of the 8x8 systolic matmul top.
- On the rising edge of the matmul's level `done`, captures the flattened 64-element accumulator matrix and requantizes each element to OUT_WIDTH (round, arithmetic shift, saturate).
- Streams the result one row (8 lanes) per beat over a valid/ready interface toward the writeback/memory side.
- Flags per-lane saturation and dropped (overrun) results.

Parameters:
- ACC_WIDTH, 16, width of each signed accumulator element in C_matrix.
- OUT_WIDTH, 8, width of each signed requantized output element; must satisfy 2 <= OUT_WIDTH <= ACC_WIDTH.
- SHIFT_W, 4, width of the shift_amt port; must satisfy 2^SHIFT_W - 1 <= ACC_WIDTH.

Ports:
- clk  input  1  Single clock; all logic is on its rising edge.
- reset  input  1  Synchronous, active-high reset.
- done_in  input  1  Level from the matmul top. Stays high once the result is final. Only a 0->1 transition triggers a capture.
- C_matrix  input  ACC_WIDTH*64  Signed, row-major. Element (r,c) is at bits [(r*8+c)*ACC_WIDTH +: ACC_WIDTH].
- shift_amt  input  SHIFT_W  Right-shift amount; sampled only on the capture cycle.
- m_valid  output  1  Output row valid.
- m_ready  input  1  Sink ready.
- m_data  output  OUT_WIDTH*8  Requantized row; lane c is at bits [c*OUT_WIDTH +: OUT_WIDTH].
- m_row  output  3  Index of the row currently presented.
- m_last  output  1  High when m_row==7.
- m_sat  output  8  Per-lane saturation flag for the presented row.
- busy  output  1  High from the capture edge until the final handshake completes.
- overrun  output  1  Sticky; set when a capture trigger arrives while busy. Cleared only by reset.

Behaviour:
- Reset (synchronous): state=IDLE; m_valid=0, m_row=0, m_last=0, m_sat=0, m_data=0, busy=0, overrun=0; done_prev=0.
  - Buffer contents after reset are don't-care.
  - A done_in already high in the first cycle after reset counts as a rising edge. In-system, matmul `done` resets on the same reset, so this is benign.
- Trigger: trig = done_in & ~done_prev. done_prev <= done_in every cycle, in all states.
- State machine, IDLE -> STREAM:
  - In IDLE with trig=1, at that clock edge: all 64 elements are requantized and written to the internal buffer (64 x OUT_WIDTH data + 64 sat bits); shift_amt is consumed.
  - Next state STREAM with m_row=0, m_valid=1, busy=1.
  - Latency: trig seen in cycle T gives row 0 valid in cycle T+1.
- State machine, STREAM:
  - Handshake is m_valid & m_ready in the same cycle.
  - If m_row<7: m_row increments at the edge, and the next row is valid the following cycle, so one row per cycle under continuous ready.
  - If m_row==7: go to IDLE; m_valid=0, busy=0, m_row=0.
  - Minimum drain is 8 cycles. The earliest subsequent capture is the cycle after returning to IDLE.
- Backpressure: while m_valid & ~m_ready, m_data, m_row, m_last and m_sat hold stable. m_valid never deasserts without a handshake.
- Overrun: trig while busy (STREAM) sets overrun=1. The new result is dropped and the stream in progress is unaffected.
- Requantization, per element x (signed ACC_WIDTH), computed at ACC_WIDTH+1 bits signed:
  - s=shift_amt. If s>0, t = x + 2^(s-1); if s=0, t = x.
  - v = t >>> s (arithmetic).
  - If v > 2^(OUT_WIDTH-1)-1: out = max, sat=1.
  - If v < -2^(OUT_WIDTH-1): out = min, sat=1.
  - Otherwise out = v[OUT_WIDTH-1:0], sat=0.
  - Rounding is round-half-up (toward +inf at exact .5).
- m_last = m_valid & (m_row==7).
- Reset mid-stream: the stream aborts immediately and nothing more is emitted. This is not reported as overrun.
- Size and structure: the buffer is registers (no RAM). The row mux selects 8 of 64 entries by m_row. The requantizer is 64 parallel instances, active only on the capture edge.

Test Plan:
- All C=100, shift=2, done_in 0->1 at cycle T, m_ready=1 -> rows 0..7 in cycles T+1..T+8, every lane=25, m_sat=0, m_last only on row 7, busy falls after T+8.
- C(0,0)=300, C(0,1)=-300, C(0,2)=127, shift=0 -> row 0 lanes 127 (sat=1), -128 (sat=1), 127 (sat=0).
- Rounding with shift=2: C=6 -> 2, C=-6 -> -1, C=-7 -> -2; with shift=1: C=5 -> 3. All sat=0.
- m_ready toggled 1,0,0,1,0,1... -> each row held stable while stalled, no row skipped or repeated, rows 0..7 in order, exactly 8 handshakes.
- Drop done_in, then raise it again at row 3 of a stream -> overrun=1 (sticky), current stream completes unchanged, no second stream follows.
- Assert reset at row 4 -> next cycle m_valid=0, busy=0, overrun=0. A fresh 0->1 of done_in then produces a full 8-row stream.
